ast_sf_buffer: RTL
==================

Name: ast_sf_buffer

Overview:
- Store-and-forward Avalon-ST packet buffer placed directly downstream of the width converter. It consumes the converter's output stream (data, sop/eop, empty, channel).
- A packet is presented downstream only once it is stored completely, so the consumer sees uninterrupted packets.
- Malformed or oversize packets are discarded and counted.

Parameters:
- DATA_W, 64, data width; equals the converter's DATA_OUT_W.
- EMPTY_W, 3, empty field width; equals EMPTY_OUT_W.
- CHANNEL_W, 10, channel width.
- DEPTH, 16, buffer depth in words; must be a power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  reset, asynchronous, active-low.
- ast_data_i  in  DATA_W  input data.
- ast_startofpacket_i  in  1  input sop.
- ast_endofpacket_i  in  1  input eop.
- ast_valid_i  in  1  input valid.
- ast_empty_i  in  EMPTY_W  empty symbols; qualified by eop.
- ast_channel_i  in  CHANNEL_W  input channel.
- ast_ready_o  out  1  input ready.
- ast_data_o  out  DATA_W  output data.
- ast_startofpacket_o  out  1  output sop.
- ast_endofpacket_o  out  1  output eop.
- ast_valid_o  out  1  output valid.
- ast_empty_o  out  EMPTY_W  output empty.
- ast_channel_o  out  CHANNEL_W  output channel.
- ast_ready_i  in  1  downstream ready.
- pkt_cnt_o  out  $clog2(DEPTH)+1  number of complete packets stored.
- drop_cnt_o  out  16  dropped-packet count; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): all pointers, counters and the FSM clear. All outputs are 0, including ast_ready_o.
- ast_ready_o is 1 from the first clock edge after reset release. The buffer never back-pressures; overflow is handled by dropping.
- Storage: memory of DEPTH words. Each word holds {data, empty, channel, sop, eop}.
- Pointers: rd_ptr, wr_ptr (committed), wr_tmp (speculative). All are $clog2(DEPTH)+1 bits and wrap naturally.
- free = DEPTH - (wr_tmp - rd_ptr).
- Write FSM states: IDLE, WR, DROP. A word is accepted when valid_i && ready_o.
  - IDLE + sop: word written at wr_tmp; wr_tmp+1; go to WR. If sop&eop in the same word, commit immediately and stay in IDLE.
  - IDLE + no sop: stray word, discarded, not counted.
  - WR + word, no sop: written. If eop, commit (wr_ptr <= wr_tmp+1, pkt_cnt+1) and go to IDLE.
  - WR + sop: the open packet is truncated. Rewind wr_tmp to wr_ptr, drop_cnt+1, then treat the word as a new sop from IDLE in the same cycle.
  - Any accepted word with free==0: rewind wr_tmp <= wr_ptr and drop_cnt+1. Go to DROP, or stay in IDLE if the word carries eop.
  - DROP: words discarded through eop, then IDLE. A sop in DROP starts a new packet, following the IDLE rule.
- Packets longer than DEPTH words are always dropped.
- Read side is show-ahead:
  - ast_valid_o = (pkt_cnt != 0).
  - Data, sop, eop and channel come from mem[rd_ptr].
  - ast_empty_o is the stored value when eop=1, otherwise 0.
  - Pop on valid_o && ready_i: rd_ptr+1. A popped eop decrements pkt_cnt.
- Latency: eop accepted at edge N gives valid_o high after edge N (registered pkt_cnt). Minimum in-to-out latency is 1 cycle.
- Simultaneous commit and eop-pop in one cycle: pkt_cnt unchanged.
- Outputs hold stable while valid_o=1 and ready_i=0.
- Reset mid-packet: the partial packet and all stored packets are lost. No drop is counted.

Test Plan:
1. 4-word packet (sop on word 0, eop+empty=3 on word 3, ch=5), ready_i=1:
   - valid_o rises 1 cycle after the eop edge.
   - 4 consecutive beats out with ch=5, sop on beat 0, eop+empty=3 on beat 3.
   - empty_o=0 on beats 0-2.
   - pkt_cnt 1→0.
2. Back-to-back single-word packets (sop&eop) over 10 cycles with ready_i=0:
   - pkt_cnt reaches 10; valid_o=1; drop_cnt=0.
   - Then ready_i=1: 10 beats drain in order.
3. 17-word packet with DEPTH=16:
   - drop_cnt=1; nothing output; pkt_cnt=0.
   - Next 2-word packet is delivered intact.
4. sop at word 3 of an open packet (no eop yet):
   - drop_cnt=1; only the second packet is output.
5. Stray non-sop words in IDLE: ignored; drop_cnt unchanged; valid_o stays 0.
6. Random ready_i toggling with random 1-8-word packets:
   - Output sequence equals input minus dropped packets.
   - Outputs stable while stalled.
   - arstn_i asserted mid-packet clears all outputs asynchronously.

Source files
------------

// File: rtl/ast_sf_buffer_if.sv
// Avalon-ST bundle for the store-and-forward buffer: upstream stream in, downstream stream out,
// plus the packet/drop status counters.
interface ast_sf_buffer_if #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned EMPTY_W   = 3,
   parameter int unsigned CHANNEL_W = 10,
   parameter int unsigned DEPTH     = 16
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0]    ast_data_i;
   logic                 ast_startofpacket_i;
   logic                 ast_endofpacket_i;
   logic                 ast_valid_i;
   logic [EMPTY_W-1:0]   ast_empty_i;
   logic [CHANNEL_W-1:0] ast_channel_i;
   logic                 ast_ready_o;

   logic [DATA_W-1:0]    ast_data_o;
   logic                 ast_startofpacket_o;
   logic                 ast_endofpacket_o;
   logic                 ast_valid_o;
   logic [EMPTY_W-1:0]   ast_empty_o;
   logic [CHANNEL_W-1:0] ast_channel_o;
   logic                 ast_ready_i;

   logic [CNT_W-1:0]     pkt_cnt_o;
   logic [15:0]          drop_cnt_o;

   modport slave (
      input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
             ast_empty_i, ast_channel_i, ast_ready_i,
      output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
             ast_valid_o, ast_empty_o, ast_channel_o, pkt_cnt_o, drop_cnt_o
   );

   modport master (
      output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
             ast_empty_i, ast_channel_i, ast_ready_i,
      input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
             ast_valid_o, ast_empty_o, ast_channel_o, pkt_cnt_o, drop_cnt_o
   );
endinterface

// File: rtl/ast_sf_buffer.sv
// Store-and-forward Avalon-ST packet buffer: packets are released downstream only once fully
// stored; truncated or oversize packets are discarded and counted.
module ast_sf_buffer #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned EMPTY_W   = 3,
   parameter int unsigned CHANNEL_W = 10,
   parameter int unsigned DEPTH     = 16
) (
   input logic          clk_i,
   input logic          arstn_i,
   ast_sf_buffer_if.slave bus
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR   = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [EMPTY_W-1:0]   empty;
      logic [CHANNEL_W-1:0] channel;
      logic                 sop;
      logic                 eop;
   } word_t;

   word_t            mem_q [DEPTH];
   logic [1:0]       state_q,    state_d;
   logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0] wr_tmp_q,   wr_tmp_d;
   logic [PTR_W-1:0] pkt_cnt_q,  pkt_cnt_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             ready_q,    ready_d;
   logic             valid_q,    valid_d;

   logic             we;
   logic [AW-1:0]    waddr;
   logic [1:0]       drops;
   logic             commit;
   logic             pop;
   logic [PTR_W-1:0] base;
   logic [PTR_W-1:0] free;
   logic [1:0]       st;
   logic [16:0]      drop_sum;
   word_t            wr_word;
   word_t            rd_word;

   assign wr_word = '{data:    bus.ast_data_i,
                      empty:   bus.ast_empty_i,
                      channel: bus.ast_channel_i,
                      sop:     bus.ast_startofpacket_i,
                      eop:     bus.ast_endofpacket_i};

   assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

   // Write side: a sop inside an open packet first rewinds it, then is handled as a fresh sop.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      wr_tmp_d = wr_tmp_q;
      drops    = 2'd0;
      commit   = 1'b0;
      we       = 1'b0;
      waddr    = wr_tmp_q[AW-1:0];
      base     = wr_tmp_q;
      st       = state_q;
      free     = '0;
      if (bus.ast_valid_i && ready_q) begin
         if (state_q == ST_WR && wr_word.sop) begin
            drops    = 2'd1;
            base     = wr_ptr_q;
            st       = ST_IDLE;
            wr_tmp_d = wr_ptr_q;
            state_d  = ST_IDLE;
         end
         free = PTR_W'(DEPTH) - (base - rd_ptr_q);
         if (st != ST_WR && !wr_word.sop) begin
            if (st == ST_DROP && wr_word.eop) state_d = ST_IDLE;
         end else if (free == '0) begin
            drops    = drops + 2'd1;
            wr_tmp_d = wr_ptr_q;
            state_d  = wr_word.eop ? ST_IDLE : ST_DROP;
         end else begin
            we       = 1'b1;
            waddr    = base[AW-1:0];
            wr_tmp_d = base + PTR_W'(1);
            if (wr_word.eop) begin
               commit   = 1'b1;
               wr_ptr_d = base + PTR_W'(1);
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_WR;
            end
         end
      end
   end

   // Read side and counters; a commit and an eop-pop in one cycle cancel out.
   always_comb begin
      ready_d   = 1'b1;
      pop       = valid_q && bus.ast_ready_i;
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
      pkt_cnt_d = pkt_cnt_q;
      if (commit && !(pop && rd_word.eop))      pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
      else if (!commit && (pop && rd_word.eop)) pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
      valid_d    = (pkt_cnt_d != '0);
      drop_sum   = 17'(drop_cnt_q) + 17'(drops);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q    <= ST_IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         wr_tmp_q   <= '0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_tmp_q   <= wr_tmp_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
      end
   end

   // Storage is cleared on reset so the show-ahead outputs read back as zero.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wr_word;
      end
   end

   assign bus.ast_ready_o         = ready_q;
   assign bus.ast_valid_o         = valid_q;
   assign bus.ast_data_o          = rd_word.data;
   assign bus.ast_startofpacket_o = rd_word.sop;
   assign bus.ast_endofpacket_o   = rd_word.eop;
   assign bus.ast_channel_o       = rd_word.channel;
   assign bus.ast_empty_o         = rd_word.eop ? rd_word.empty : '0;
   assign bus.pkt_cnt_o           = pkt_cnt_q;
   assign bus.drop_cnt_o          = drop_cnt_q;
endmodule
